// File: rtl/target_bbox.sv
// -----------------------------------------------------------------------------
// target_bbox
//   Consumes the per-pixel colour-match bit stream and collects statistics for
//   one frame: the bounding box and the number of matched pixels. On every
//   frame boundary (rising edge of pix_vsync) it publishes the frame result.
//
//   Optional build macro: TARGET_BBOX_CENTROID_EN
//     When defined, the block also sums the x and y coordinates of the matched
//     pixels. At the frame boundary it divides each sum by the pixel count with
//     two bit-serial restoring dividers, which gives the centroid (cx, cy). All
//     results are then published together when the division finishes. When the
//     macro is not defined, cx = cy = 0 and busy = 0.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   pix_de       active-video enable, one pixel per clk while high
//   pix_vsync    vertical sync, active high; its rising edge ends a frame
//   bin_in       colour-match bit for the current pixel (valid with pix_de)
//   x_min/x_max  horizontal extent of the matched pixels in the last frame
//   y_min/y_max  vertical extent of the matched pixels in the last frame
//   pix_count    number of matched pixels in the last frame
//   target_found pix_count >= MIN_PIX
//   cx/cy        centroid of the matched pixels (0 without the centroid build)
//   result_valid one-cycle pulse when all results update
//   busy         centroid division in progress (0 without the centroid build)
// -----------------------------------------------------------------------------
module target_bbox #(
  parameter int XW      = 11,
  parameter int YW      = 10,
  parameter int CW      = 20,
  parameter int MIN_PIX = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_de,
  input  logic          pix_vsync,
  input  logic          bin_in,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] pix_count,
  output logic          target_found,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          result_valid,
  output logic          busy
);

  localparam logic [XW-1:0] X_SAT = '1;
  localparam logic [YW-1:0] Y_SAT = '1;
  localparam logic [CW-1:0] C_SAT = '1;
  localparam logic [CW-1:0] C_MIN = CW'(MIN_PIX);

  // ---------------------------------------------------------------------------
  // Pixel coordinates and frame-edge detection
  // ---------------------------------------------------------------------------
  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic          de_d_reg;
  logic          vs_d_reg;
  logic          vs_edge;
  logic          hit;

  assign vs_edge = pix_vsync & ~vs_d_reg;
  // A pixel that arrives in the edge cycle belongs to no frame, so it is dropped.
  assign hit     = pix_de & bin_in & ~vs_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      de_d_reg <= 1'b0;
      vs_d_reg <= 1'b0;
    end else begin
      de_d_reg <= pix_de;
      vs_d_reg <= pix_vsync;
      if (!pix_de)
        x_reg <= '0;
      else if (x_reg != X_SAT)
        x_reg <= x_reg + 1'b1;
      // The frame edge has priority, so the first line of every frame is y = 0.
      if (vs_edge)
        y_reg <= '0;
      else if (de_d_reg && !pix_de && (y_reg != Y_SAT))
        y_reg <= y_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame accumulators
  // ---------------------------------------------------------------------------
  logic [XW-1:0] acc_x_min, acc_x_max;
  logic [YW-1:0] acc_y_min, acc_y_max;
  logic [CW-1:0] acc_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x_min <= X_SAT;
      acc_x_max <= '0;
      acc_y_min <= Y_SAT;
      acc_y_max <= '0;
      acc_count <= '0;
    end else if (vs_edge) begin
      acc_x_min <= X_SAT;
      acc_x_max <= '0;
      acc_y_min <= Y_SAT;
      acc_y_max <= '0;
      acc_count <= '0;
    end else if (hit) begin
      if (x_reg < acc_x_min) acc_x_min <= x_reg;
      if (x_reg > acc_x_max) acc_x_max <= x_reg;
      if (y_reg < acc_y_min) acc_y_min <= y_reg;
      if (y_reg > acc_y_max) acc_y_max <= y_reg;
      if (acc_count != C_SAT) acc_count <= acc_count + 1'b1;
    end
  end

  // Frame result as it would be reported now. In an empty frame the min
  // registers still hold their all-ones start value, so they are forced to 0.
  logic          frame_empty;
  logic [XW-1:0] snap_x_min, snap_x_max;
  logic [YW-1:0] snap_y_min, snap_y_max;
  logic          snap_found;

  assign frame_empty = (acc_count == '0);
  assign snap_x_min  = frame_empty ? '0 : acc_x_min;
  assign snap_x_max  = acc_x_max;
  assign snap_y_min  = frame_empty ? '0 : acc_y_min;
  assign snap_y_max  = acc_y_max;
  assign snap_found  = (acc_count >= C_MIN);

  // Source of the next published result set
  logic          publish;
  logic [XW-1:0] pub_x_min, pub_x_max, pub_cx;
  logic [YW-1:0] pub_y_min, pub_y_max, pub_cy;
  logic [CW-1:0] pub_count;
  logic          pub_found;

`ifdef TARGET_BBOX_CENTROID_EN
  // ---------------------------------------------------------------------------
  // Centroid: coordinate sums and two bit-serial restoring dividers
  // ---------------------------------------------------------------------------
  localparam int SW  = XW + CW;
  localparam int STW = $clog2(SW + 1);

  logic            busy_reg;
  logic            done_reg;
  logic [STW-1:0]  step_reg;
  logic [CW-1:0]   divisor_reg;
  logic [XW-1:0]   pend_x_min, pend_x_max;
  logic [YW-1:0]   pend_y_min, pend_y_max;
  logic [CW-1:0]   pend_count;
  logic            pend_found;
  logic            div_start;
  logic            div_step;
  logic [SW-1:0]   quot [2];

  assign div_start = vs_edge & ~frame_empty;
  // A new frame edge restarts the dividers, which drops the result in progress.
  assign div_step  = busy_reg & ~vs_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      step_reg    <= '0;
      divisor_reg <= '0;
      pend_x_min  <= '0;
      pend_x_max  <= '0;
      pend_y_min  <= '0;
      pend_y_max  <= '0;
      pend_count  <= '0;
      pend_found  <= 1'b0;
    end else if (vs_edge) begin
      busy_reg    <= ~frame_empty;
      done_reg    <= 1'b0;
      step_reg    <= '0;
      divisor_reg <= acc_count;
      pend_x_min  <= snap_x_min;
      pend_x_max  <= snap_x_max;
      pend_y_min  <= snap_y_min;
      pend_y_max  <= snap_y_max;
      pend_count  <= acc_count;
      pend_found  <= snap_found;
    end else if (busy_reg) begin
      step_reg <= step_reg + 1'b1;
      if (step_reg == STW'(SW - 1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  // gi = 0 handles x, gi = 1 handles y. Once all SW steps are done, the
  // dividend register holds the quotient.
  for (genvar gi = 0; gi < 2; gi++) begin : g_div
    logic [SW-1:0] coord;
    logic [SW-1:0] sum_reg;
    logic [SW-1:0] dvd_reg;
    logic [CW-1:0] rem_reg;
    logic [SW:0]   sum_add;
    logic [CW:0]   rem_shift;
    logic          rem_ge;

    assign coord     = (gi == 0) ? SW'(x_reg) : SW'(y_reg);
    assign sum_add   = {1'b0, sum_reg} + {1'b0, coord};
    assign rem_shift = {rem_reg, dvd_reg[SW-1]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor_reg});

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_reg <= '0;
        dvd_reg <= '0;
        rem_reg <= '0;
      end else begin
        if (vs_edge)
          sum_reg <= '0;
        else if (hit)
          sum_reg <= sum_add[SW] ? '1 : sum_add[SW-1:0];

        if (div_start) begin
          dvd_reg <= sum_reg;
          rem_reg <= '0;
        end else if (div_step) begin
          dvd_reg <= {dvd_reg[SW-2:0], rem_ge};
          rem_reg <= rem_ge ? CW'(rem_shift - {1'b0, divisor_reg}) : rem_shift[CW-1:0];
        end
      end
    end

    assign quot[gi] = dvd_reg;
  end

  // An empty frame needs no division and is published straight from the edge.
  assign publish   = (vs_edge & frame_empty) | (done_reg & ~vs_edge);
  assign pub_x_min = vs_edge ? snap_x_min : pend_x_min;
  assign pub_x_max = vs_edge ? snap_x_max : pend_x_max;
  assign pub_y_min = vs_edge ? snap_y_min : pend_y_min;
  assign pub_y_max = vs_edge ? snap_y_max : pend_y_max;
  assign pub_count = vs_edge ? acc_count  : pend_count;
  assign pub_found = vs_edge ? snap_found : pend_found;
  assign pub_cx    = vs_edge ? '0 : quot[0][XW-1:0];
  assign pub_cy    = vs_edge ? '0 : quot[1][YW-1:0];
  assign busy      = busy_reg;
`else
  assign publish   = vs_edge;
  assign pub_x_min = snap_x_min;
  assign pub_x_max = snap_x_max;
  assign pub_y_min = snap_y_min;
  assign pub_y_max = snap_y_max;
  assign pub_count = acc_count;
  assign pub_found = snap_found;
  assign pub_cx    = '0;
  assign pub_cy    = '0;
  assign busy      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Published result registers (they hold between result_valid pulses)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      pix_count    <= '0;
      target_found <= 1'b0;
      cx           <= '0;
      cy           <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= publish;
      if (publish) begin
        x_min        <= pub_x_min;
        x_max        <= pub_x_max;
        y_min        <= pub_y_min;
        y_max        <= pub_y_max;
        pix_count    <= pub_count;
        target_found <= pub_found;
        cx           <= pub_cx;
        cy           <= pub_cy;
      end
    end
  end

endmodule

// File: tb/tb_target_bbox.sv
// -----------------------------------------------------------------------------
// tb_target_bbox
//   Self-checking bench for target_bbox. Each frame is described as a set of
//   matched (x, y) points. The expected bounding box, count, threshold flag,
//   centroid and latency are derived directly from that set. Line lengths
//   vary, so that far-out pixels can be reached without full 640x480 frames.
// -----------------------------------------------------------------------------
module tb_target_bbox;

  localparam int XW      = 11;
  localparam int YW      = 10;
  localparam int CW      = 20;
  localparam int MIN_PIX = 64;
  localparam int SW      = XW + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_de = 1'b0;
  logic          pix_vsync = 1'b0;
  logic          bin_in = 1'b0;
  logic [XW-1:0] x_min, x_max, cx;
  logic [YW-1:0] y_min, y_max, cy;
  logic [CW-1:0] pix_count;
  logic          target_found, result_valid, busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int rv_pulses = 0;
  int px[$];
  int py[$];

  target_bbox #(.XW(XW), .YW(YW), .CW(CW), .MIN_PIX(MIN_PIX)) dut (
    .clk(clk), .rst_n(rst_n), .pix_de(pix_de), .pix_vsync(pix_vsync),
    .bin_in(bin_in), .x_min(x_min), .x_max(x_max), .y_min(y_min),
    .y_max(y_max), .pix_count(pix_count), .target_found(target_found),
    .cx(cx), .cy(cy), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counts the cycles with result_valid high, so that pulse width and aborted
  // pulses can be checked.
  always @(negedge clk) if (result_valid === 1'b1) rv_pulses++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_hit(input int x, input int y);
    foreach (px[i]) if (px[i] == x && py[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_pt(input int x, input int y);
    if (!is_hit(x, y)) begin
      px.push_back(x);
      py.push_back(y);
    end
  endtask

  task automatic clear_pts;
    px.delete();
    py.delete();
  endtask

  // Drives nlines active lines. A line is def_len pixels long, or longer when
  // a point lies further right. bin_in carries noise while pix_de is low.
  task automatic drive_lines(input int nlines, input int def_len);
    int len;
    for (int y = 0; y < nlines; y++) begin
      len = def_len;
      foreach (px[i]) if (py[i] == y && px[i] + 1 > len) len = px[i] + 1;
      for (int x = 0; x < len; x++) begin
        tick;
        pix_de = 1'b1;
        bin_in = is_hit(x, y);
      end
      tick;
      pix_de = 1'b0;
      bin_in = 1'($urandom);
      tick;
      bin_in = 1'b0;
    end
  endtask

  // Raises vsync, then checks latency, busy, pulse width and every output
  // against the values computed from the point set.
  task automatic vsync_check(input string name, input bit edge_pix);
    int cnt, lat, exp_busy, busy_n, p0;
    longint sx, sy;
    logic [63:0] ex_min, ex_max, ey_min, ey_max, ecx, ecy, held;
    bit early;
    cnt = px.size();
    ex_min = 0; ex_max = 0; ey_min = 0; ey_max = 0; sx = 0; sy = 0;
    if (cnt > 0) begin
      ex_min = px.min()[0]; ex_max = px.max()[0];
      ey_min = py.min()[0]; ey_max = py.max()[0];
      foreach (px[i]) begin sx += px[i]; sy += py[i]; end
    end
    ecx = 0; ecy = 0; lat = 1; exp_busy = 0;
`ifdef TARGET_BBOX_CENTROID_EN
    if (cnt > 0) begin
      ecx = (sx / cnt) % (64'd1 << XW);
      ecy = (sy / cnt) % (64'd1 << YW);
      lat = SW + 2;
      exp_busy = SW;
    end
`endif
    p0 = rv_pulses; early = 1'b0; busy_n = 0;
    tick;
    pix_vsync = 1'b1;
    if (edge_pix) begin pix_de = 1'b1; bin_in = 1'b1; end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (result_valid !== 1'b0) early = 1'b1;
      if (busy === 1'b1) busy_n++;
      if (k == 0) begin pix_de = 1'b0; bin_in = 1'b0; end
    end
    @(negedge clk);
    check($sformatf("%s_valid", name), result_valid, 1);
    check($sformatf("%s_xmin", name), x_min, ex_min);
    check($sformatf("%s_xmax", name), x_max, ex_max);
    check($sformatf("%s_ymin", name), y_min, ey_min);
    check($sformatf("%s_ymax", name), y_max, ey_max);
    check($sformatf("%s_count", name), pix_count, cnt);
    check($sformatf("%s_found", name), target_found, (cnt >= MIN_PIX) ? 1 : 0);
    check($sformatf("%s_cx", name), cx, ecx);
    check($sformatf("%s_cy", name), cy, ecy);
    check($sformatf("%s_early", name), early, 0);
    check($sformatf("%s_busy", name), busy_n, exp_busy);
    held = x_max;
    repeat (3) @(negedge clk);
    pix_vsync = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("%s_hold", name), x_max, held);
    check($sformatf("%s_pulses", name), rv_pulses - p0, 1);
    $display("frame %s: count=%0d bbox=%0d/%0d/%0d/%0d found=%0d cx=%0d cy=%0d",
             name, pix_count, x_min, x_max, y_min, y_max, target_found, cx, cy);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_xmin", x_min, 0);
    check("rst_xmax", x_max, 0);
    check("rst_ymin", y_min, 0);
    check("rst_ymax", y_max, 0);
    check("rst_count", pix_count, 0);
    check("rst_found", target_found, 0);
    check("rst_valid", result_valid, 0);
    check("rst_cx", cx, 0);
    check("rst_cy", cy, 0);
    check("rst_busy", busy, 0);
    tick;
    rst_n = 1'b1;

    // Partial frame discarded by a reset mid-line
    clear_pts();
    for (int i = 0; i < 3; i++) add_pt(2 + i, i);
    drive_lines(3, 20);
    for (int x = 0; x < 5; x++) begin tick; pix_de = 1'b1; bin_in = 1'b1; end
    tick;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_count", pix_count, 0);
    check("midrst_valid", result_valid, 0);
    tick;
    pix_de = 1'b0; bin_in = 1'b0; rst_n = 1'b1;
    tick;
    clear_pts();
    vsync_check("after_reset", 0);

    // 10x10 block
    clear_pts();
    for (int y = 50; y < 60; y++) for (int x = 100; x < 110; x++) add_pt(x, y);
    drive_lines(60, 16);
    vsync_check("block", 0);
    check("block_const_xmin", x_min, 100);
    check("block_const_ymax", y_max, 59);

    // Empty frame right after the block: nothing carries over
    clear_pts();
    drive_lines(4, 8);
    vsync_check("empty", 0);

    // Sparse pixels below threshold, far corners
    clear_pts();
    add_pt(3, 7);    add_pt(600, 470); add_pt(10, 100); add_pt(200, 300);
    add_pt(50, 20);  add_pt(400, 9);   add_pt(599, 469); add_pt(30, 450);
    drive_lines(471, 1);
    vsync_check("sparse", 0);

    // Pixel in the edge cycle is not counted; the following frame is empty
    clear_pts();
    add_pt(1, 0); add_pt(4, 1); add_pt(7, 2);
    drive_lines(3, 8);
    vsync_check("edgepix", 1);
    clear_pts();
    drive_lines(2, 4);
    vsync_check("after_edge", 0);

    // Origin pixel: first pixel of the first line is (0,0)
    clear_pts();
    add_pt(0, 0); add_pt(5, 3);
    drive_lines(4, 8);
    vsync_check("origin", 0);

    // Threshold boundary: MIN_PIX-1 and MIN_PIX distinct pixels
    for (int t = MIN_PIX - 1; t <= MIN_PIX; t++) begin
      clear_pts();
      while (px.size() < t) add_pt($urandom_range(0, 63), $urandom_range(0, 15));
      drive_lines(16, 64);
      vsync_check($sformatf("thresh%0d", t), 0);
    end

    // Random frames
    for (int f = 0; f < 5; f++) begin
      clear_pts();
      n = $urandom_range(0, 150);
      for (int i = 0; i < n; i++) add_pt($urandom_range(0, 63), $urandom_range(0, 31));
      drive_lines(32, 64);
      vsync_check($sformatf("rand%0d", f), 0);
    end

`ifdef TARGET_BBOX_CENTROID_EN
    // Second edge while dividing: the first frame never publishes
    begin
      int p0;
      clear_pts();
      for (int y = 0; y < 3; y++) for (int x = 2; x < 6; x++) add_pt(x, y);
      drive_lines(3, 8);
      p0 = rv_pulses;
      tick;
      pix_vsync = 1'b1;
      repeat (3) tick;
      pix_vsync = 1'b0;
      tick;
      clear_pts();
      add_pt(3, 0); add_pt(7, 0); add_pt(11, 0);
      drive_lines(1, 12);
      vsync_check("abort2", 0);
      check("abort_total_pulses", rv_pulses - p0, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
